// File: rtl/uart_irq_ctrl.sv
// 16550 interrupt scheduler: fixed-priority arbitration, char-timeout timer, THRE latch.
// Optional modem-status source compiled in with `define UART_MSR_IRQ_EN.
module uart_irq_ctrl #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    ier,
  input  logic                          fifo_en,
  input  logic [1:0]                    rx_trigger,
  input  logic [1:0]                    wls,
  input  logic                          stb,
  input  logic                          pen,
  input  logic [3:0]                    lsr_err,
  input  logic                          dr,
  input  logic                          thre,
  input  logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic                          rx_push,
  input  logic                          rx_pop,
  input  logic                          thr_write,
  input  logic                          iir_read,
  input  logic                          baud_tick,
  input  logic                          msr_delta,
  output logic [7:0]                    iir,
  output logic                          irq
);

  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int MAX_THRESH = 4 * 12 * TICKS_PER_BIT;
  localparam int CNT_W      = $clog2(MAX_THRESH + 1);

  logic [LVL_W-1:0] trig_level;
  logic [3:0]       char_bits;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_flag, flag_nxt;
  logic             thre_pending, pend_nxt;
  logic             thre_q, ier1_q;
  logic             rda_cond, cnt_clr, thre_set;
  logic [3:0]       iir_id_nxt;

  always_comb begin
    case (rx_trigger)
      2'b00:   trig_level = LVL_W'(1);
      2'b01:   trig_level = LVL_W'(4);
      2'b10:   trig_level = LVL_W'(8);
      default: trig_level = LVL_W'(14);
    endcase
  end

  assign rda_cond = fifo_en ? (rx_level >= trig_level) : dr;

  // start + (5+wls) data + parity + stop; 1.5 stop bits round up to 2
  assign char_bits = 4'd6 + {2'b00, wls} + {3'b000, pen} + (stb ? 4'd2 : 4'd1);
  assign thresh    = CNT_W'(char_bits) * CNT_W'(4 * TICKS_PER_BIT);

  assign cnt_clr = rx_push | rx_pop | ~fifo_en | ~(|rx_level);

  always_comb begin
    cnt_nxt = cnt;
    if (cnt_clr)
      cnt_nxt = '0;
    else if (baud_tick && (cnt < thresh))
      cnt_nxt = cnt + 1'b1;
  end

  assign flag_nxt = cnt_clr ? 1'b0 : (timeout_flag | (cnt_nxt >= thresh));

  // thr_write beats any set; a set beats an iir_read clear
  assign thre_set = (thre & ~thre_q) | (ier[1] & ~ier1_q & thre);

  always_comb begin
    pend_nxt = thre_pending;
    if (thr_write)
      pend_nxt = 1'b0;
    else if (thre_set)
      pend_nxt = 1'b1;
    else if (iir_read && (iir[3:0] == 4'b0010))
      pend_nxt = 1'b0;
  end

  // Sources are judged on next-state flags so iir follows inputs by one cycle
  always_comb begin
    iir_id_nxt = 4'b0001;
    if (ier[2] && (|lsr_err))
      iir_id_nxt = 4'b0110;
    else if (ier[0] && rda_cond)
      iir_id_nxt = 4'b0100;
    else if (ier[0] && fifo_en && flag_nxt)
      iir_id_nxt = 4'b1100;
    else if (ier[1] && pend_nxt)
      iir_id_nxt = 4'b0010;
`ifdef UART_MSR_IRQ_EN
    else if (ier[3] && msr_delta)
      iir_id_nxt = 4'b0000;
`endif
  end

`ifndef UART_MSR_IRQ_EN
  logic unused_msr;
  assign unused_msr = ^{msr_delta, ier[3]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
      thre_pending <= 1'b0;
      thre_q       <= 1'b0;
      ier1_q       <= 1'b0;
      iir          <= 8'h01;
      irq          <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      timeout_flag <= flag_nxt;
      thre_pending <= pend_nxt;
      thre_q       <= thre;
      ier1_q       <= ier[1];
      iir          <= {fifo_en, fifo_en, 2'b00, iir_id_nxt};
      irq          <= ~iir_id_nxt[0];
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Scoreboard bench for uart_irq_ctrl: stimulus queues expected {irq,iir} changes,
// a negedge monitor pops one entry per observed output change.
module tb_uart_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ier, lsr_err;
  logic       fifo_en, stb, pen, dr, thre;
  logic [1:0] rx_trigger, wls;
  logic [4:0] rx_level;
  logic       rx_push, rx_pop, thr_write, iir_read, baud_tick, msr_delta;
  logic [7:0] iir;
  logic       irq;

  typedef struct {
    logic [8:0] val;
    int         at;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  uart_irq_ctrl #(.FIFO_DEPTH(16), .TICKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .ier(ier), .fifo_en(fifo_en), .rx_trigger(rx_trigger),
    .wls(wls), .stb(stb), .pen(pen), .lsr_err(lsr_err), .dr(dr), .thre(thre),
    .rx_level(rx_level), .rx_push(rx_push), .rx_pop(rx_pop), .thr_write(thr_write),
    .iir_read(iir_read), .baud_tick(baud_tick), .msr_delta(msr_delta),
    .iir(iir), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [8:0] act,
                             input logic [8:0] exp, input int at);
    n_checks++;
    if (act === exp && (at < 0 || at == cyc))
      n_pass++;
    else
      $display("[TB] FAIL %s: got irq/iir=%0b/%02h at cycle %0d, expected %0b/%02h at cycle %0d",
               name, act[8], act[7:0], cyc, exp[8], exp[7:0], at);
  endtask

  // Optionally queue the change the next clock edge must produce, then take that edge
  task automatic applyStimulus(input bit has_exp, input logic [8:0] val, input string name);
    exp_t e;
    if (has_exp) begin
      e.val = val; e.at = cyc + 1; e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 9'h0, "");
  endtask

  initial begin : monitor
    logic [8:0] prev, cur;
    exp_t e;
    prev = 9'h0FF;
    forever begin
      @(negedge clk);
      cur = {irq, iir};
      if (cur !== prev) begin
        if (exp_q.size() == 0)
          checkOutput("unexpected_change", cur, prev, -1);
        else begin
          e = exp_q.pop_front();
          checkOutput(e.name, cur, e.val, e.at);
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    rst = 1'b1; ier = 4'h0; lsr_err = 4'h0; fifo_en = 0; stb = 0; pen = 0; dr = 0;
    thre = 0; rx_trigger = 2'b00; wls = 2'b00; rx_level = 5'd0; rx_push = 0;
    rx_pop = 0; thr_write = 0; iir_read = 0; baud_tick = 0; msr_delta = 0;
    e.val = {1'b0, 8'h01}; e.at = -1; e.name = "reset";
    exp_q.push_back(e);
    idle(3);
    rst = 1'b0;
    idle(2);

    // modem-status source only exists when the macro is compiled in
    ier = 4'b1000; msr_delta = 1'b1;
`ifdef UART_MSR_IRQ_EN
    applyStimulus(1, {1'b1, 8'h00}, "ms_raise");
    msr_delta = 1'b0;
    applyStimulus(1, {1'b0, 8'h01}, "ms_drop");
`else
    idle(3);
    msr_delta = 1'b0;
    idle(1);
`endif

    // THRE raise, clear by IIR read, re-raise, clear by THR write
    ier = 4'b0010;
    idle(1);
    thre = 1'b1;
    applyStimulus(1, {1'b1, 8'h02}, "thre_raise");
    iir_read = 1'b1;
    applyStimulus(1, {1'b0, 8'h01}, "thre_iir_read_clear");
    iir_read = 1'b0;
    idle(2);
    thre = 1'b0;
    idle(1);
    thre = 1'b1;
    applyStimulus(1, {1'b1, 8'h02}, "thre_reraise");
    thr_write = 1'b1;
    applyStimulus(1, {1'b0, 8'h01}, "thre_thr_write_clear");
    thr_write = 1'b0;

    // thr_write with a thre rising edge: pending must stay clear
    thre = 1'b0;
    idle(1);
    thre = 1'b1; thr_write = 1'b1;
    idle(1);
    thr_write = 1'b0;
    idle(3);

    // iir_read with an ier[1] rising edge while thre=1: THRE still asserted
    ier = 4'b0000;
    idle(1);
    ier = 4'b0010; iir_read = 1'b1;
    applyStimulus(1, {1'b1, 8'h02}, "ier1_rise_vs_iir_read");
    iir_read = 1'b0;
    thr_write = 1'b1;
    applyStimulus(1, {1'b0, 8'h01}, "thre_clear2");
    thr_write = 1'b0;
    ier = 4'b0000; thre = 1'b0;
    idle(1);

    // trigger levels and RLS over RDA priority
    fifo_en = 1'b1; rx_trigger = 2'b01; ier = 4'b0101;
    applyStimulus(1, {1'b0, 8'hC1}, "fifo_en_bits");
    rx_level = 5'd3;
    idle(2);
    rx_level = 5'd4;
    applyStimulus(1, {1'b1, 8'hC4}, "rda_trig4");
    lsr_err = 4'b0001;
    applyStimulus(1, {1'b1, 8'hC6}, "rls_over_rda");
    lsr_err = 4'b0000;
    applyStimulus(1, {1'b1, 8'hC4}, "rls_drop");
    rx_trigger = 2'b11;
    applyStimulus(1, {1'b0, 8'hC1}, "trig14_below");
    rx_level = 5'd14;
    applyStimulus(1, {1'b1, 8'hC4}, "trig14_at");
    rx_level = 5'd13;
    applyStimulus(1, {1'b0, 8'hC1}, "trig14_13");
    fifo_en = 1'b0; rx_level = 5'd0; dr = 1'b1;
    applyStimulus(1, {1'b1, 8'h04}, "rda_nonfifo_dr");
    dr = 1'b0;
    applyStimulus(1, {1'b0, 8'h01}, "rda_nonfifo_clear");
    ier = 4'b0000; lsr_err = 4'b1111;
    idle(2);
    lsr_err = 4'b0000;
    idle(1);

    // character timeout: cb=10 -> 640 ticks
    fifo_en = 1'b1; ier = 4'b0001; rx_trigger = 2'b11; wls = 2'b11; pen = 0; stb = 0;
    rx_level = 5'd1;
    applyStimulus(1, {1'b0, 8'hC1}, "cti_setup");
    baud_tick = 1'b1;
    idle(639);
    baud_tick = 1'b0;
    idle(3);
    baud_tick = 1'b1;
    applyStimulus(1, {1'b1, 8'hCC}, "cti_640");
    idle(5);
    baud_tick = 1'b0;
    rx_pop = 1'b1; rx_level = 5'd0;
    applyStimulus(1, {1'b0, 8'hC1}, "cti_pop_clear");
    rx_pop = 1'b0;
    idle(1);

    // reset at tick 500 restarts the timeout from zero
    rx_level = 5'd1;
    idle(1);
    baud_tick = 1'b1;
    idle(500);
    baud_tick = 1'b0;
    rst = 1'b1;
    e.val = {1'b0, 8'h01}; e.at = cyc; e.name = "mid_timeout_reset";
    exp_q.push_back(e);
    idle(2);
    rst = 1'b0;
    applyStimulus(1, {1'b0, 8'hC1}, "post_reset_fifo_bits");
    baud_tick = 1'b1;
    idle(639);
    baud_tick = 1'b0;
    idle(3);
    baud_tick = 1'b1;
    applyStimulus(1, {1'b1, 8'hCC}, "cti_after_reset");
    baud_tick = 1'b0;
    idle(5);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("[TB] FAIL %s: expected irq/iir=%0b/%02h never observed, got %0b/%02h",
               e.name, e.val[8], e.val[7:0], irq, iir);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
